// File: rtl/tdm_rr_scheduler.sv
// Request-driven round-robin TDM scheduler: grants active channels only, each for a programmable burst.
// Optional TDM_STATS_EN adds a saturating grant_total counter output.
module tdm_rr_scheduler #(
  parameter int DATA_W  = 2,
  parameter int BURST_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         en_mask,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  output logic [3:0]         gnt,
  output logic [1:0]         gnt_id,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid
`ifdef TDM_STATS_EN
  ,
  output logic [7:0]         grant_total
`endif
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               start_grant;
  logic [3:0]         eligible;
  logic [1:0]         next_ptr;
  logic [2:0]         idle_pick, end_pick;
  logic               grant_done;
  logic [DATA_W-1:0]  sel_data;

  // Returns {found, index}: first eligible channel at or above start, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [3:0] elig);
    logic [2:0] r;
    logic [1:0] c;
    r = '0;
    for (int k = 3; k >= 0; k--) begin
      c = start + 2'(k);
      if (elig[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no path can infer a latch.
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    start_grant = 1'b0;
    eligible    = req & en_mask;
    next_ptr    = gnt_id_q + 2'd1;
    idle_pick   = rr_pick(ptr_q, eligible);
    end_pick    = rr_pick(next_ptr, eligible);
    // >= rather than == so a burst_len lowered below the running count still ends the grant.
    grant_done  = (cnt_q >= burst_len) || !req[gnt_id_q] || !en_mask[gnt_id_q];
    case (state_q)
      IDLE: begin
        if (idle_pick[2]) begin
          state_d     = GRANT;
          gnt_id_d    = idle_pick[1:0];
          cnt_d       = '0;
          start_grant = 1'b1;
        end
      end
      GRANT: begin
        if (grant_done) begin
          ptr_d = next_ptr;
          if (end_pick[2]) begin
            gnt_id_d    = end_pick[1:0];
            cnt_d       = '0;
            start_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + BURST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == GRANT);
    gnt_d   = valid_d ? (4'(1) << gnt_id_d) : 4'b0000;
  end

`ifdef TDM_STATS_EN
  logic [7:0] total_q, total_d;
  always_comb begin
    total_d = total_q;
    if (start_grant && (total_q != 8'hFF)) total_d = total_q + 8'd1;
  end
  assign grant_total = total_q;
`endif

  // NOTE: state registers use non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
`ifdef TDM_STATS_EN
      total_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
`ifdef TDM_STATS_EN
      total_q  <= total_d;
`endif
    end
  end

  always_comb begin
    sel_data = '0;
    case (gnt_id_q)
      2'd0:    sel_data = in0;
      2'd1:    sel_data = in1;
      2'd2:    sel_data = in2;
      default: sel_data = in3;
    endcase
  end

  assign out       = valid_q ? sel_data : '0;
  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_tdm_rr_scheduler.sv
// Directed bench for tdm_rr_scheduler: a per-cycle behavioural model plus hand-computed grant sequences.
module tb_tdm_rr_scheduler;
  localparam int DATA_W  = 2;
  localparam int BURST_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req, en_mask;
  logic [BURST_W-1:0] burst_len;
  logic [DATA_W-1:0]  din [4];
  logic [3:0]         gnt;
  logic [1:0]         gnt_id;
  logic [DATA_W-1:0]  out;
  logic               out_valid;
`ifdef TDM_STATS_EN
  logic [7:0]         grant_total;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_rr_scheduler #(.DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en_mask   (en_mask),
    .burst_len (burst_len),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .out       (out),
    .out_valid (out_valid)
`ifdef TDM_STATS_EN
    ,
    .grant_total (grant_total)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner = granted channel or -1 when idle, held = cycles already served.
  int m_owner  = -1;
  int m_held   = 0;
  int m_ptr    = 0;
  int m_last   = 0;
  int m_grants = 0;

  function automatic int pick(input int start, input logic [3:0] e);
    for (int k = 0; k < 4; k++)
      if (e[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_step();
    logic [3:0] e;
    int nxt;
    if (rst) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_grants = 0;
    end else begin
      e = req & en_mask;
      if (m_owner < 0) begin
        nxt = pick(m_ptr, e);
        if (nxt >= 0) begin m_owner = nxt; m_held = 0; m_grants++; end
      end else if (m_held >= int'(burst_len) || !req[m_owner] || !en_mask[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        nxt   = pick(m_ptr, e);
        if (nxt >= 0) begin m_owner = nxt; m_held = 0; m_grants++; end
        else m_owner = -1;
      end else begin
        m_held++;
      end
      if (m_owner >= 0) m_last = m_owner;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("model_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("model_gnt_id", gnt_id, m_last);
    check("model_valid", out_valid, m_owner >= 0);
    check("model_out", out, (m_owner >= 0) ? din[m_owner] : '0);
    check("onehot", $countones(gnt) <= 1, 1);
`ifdef TDM_STATS_EN
    check("model_total", grant_total, (m_grants > 255) ? 255 : m_grants);
`endif
  end

  task automatic nxt();
    @(negedge clk);
    for (int i = 0; i < 4; i++) din[i] = DATA_W'($urandom_range(0, 3));
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] rr_exp [4]    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] burst_exp [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100};

  initial begin
    rst = 1'b1; req = 4'hF; en_mask = 4'hF; burst_len = '0;
    for (int i = 0; i < 4; i++) din[i] = DATA_W'(i);
    edge_wait();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_gnt_id", gnt_id, 2'd0);

    nxt(); rst = 1'b0;
    edge_wait();
    check("first_gnt", gnt, 4'b0001);
    check("first_out", out, din[0]);
    for (int i = 0; i < 4; i++) begin
      nxt(); edge_wait();
      check("rr_gnt", gnt, rr_exp[i]);
    end

    nxt(); req = 4'h0;
    edge_wait();
    check("idle_valid", out_valid, 1'b0);
    check("idle_out", out, '0);
    nxt(); edge_wait();
    check("idle_gnt", gnt, 4'b0000);

    nxt(); req = 4'b0101; burst_len = 2'd2;
    for (int i = 0; i < 7; i++) begin
      edge_wait();
      check("burst_gnt", gnt, burst_exp[i]);
      nxt();
    end

    req = 4'h0;
    edge_wait();
    check("drain_gnt", gnt, 4'b0000);
    nxt(); edge_wait();
    nxt(); req = 4'b0110; burst_len = 2'd3;
    edge_wait();
    check("early_first", gnt, 4'b0010);
    nxt(); req = 4'b0100;
    edge_wait();
    check("early_move", gnt, 4'b0100);

    nxt(); req = 4'b0001; en_mask = 4'b1110;
    edge_wait();
    check("mask_gnt0", gnt, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      nxt(); edge_wait();
      check("mask_gnt", gnt, 4'b0000);
    end

    nxt(); en_mask = 4'hF; req = 4'b1000;
    edge_wait();
    check("rearm_gnt", gnt, 4'b1000);
    check("rearm_id", gnt_id, 2'd3);

    nxt(); edge_wait();
    nxt(); burst_len = 2'd0;
    edge_wait();
    check("shrink_regrant", gnt, 4'b1000);
    nxt(); req = 4'hF; burst_len = 2'd3;
    edge_wait();
    nxt(); en_mask = 4'b0111;
    edge_wait();
    check("unmask_move", gnt, 4'b0001);

    nxt(); en_mask = 4'hF;
    edge_wait();
    rst = 1'b1;
    #1;
    check("async_gnt", gnt, 4'b0000);
    check("async_valid", out_valid, 1'b0);
    check("async_out", out, '0);
    check("async_id", gnt_id, 2'd0);
    nxt(); rst = 1'b0;
    edge_wait();
    check("post_rst_gnt", gnt, 4'b0001);

`ifdef TDM_STATS_EN
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; req = 4'hF; burst_len = '0;
    for (int i = 0; i < 5; i++) edge_wait();
    check("stats_five", grant_total, 8'd5);
    #1 rst = 1'b1;
    #1;
    check("stats_rst", grant_total, 8'd0);
    check("stats_rst_gnt", gnt, 4'b0000);
    nxt(); rst = 1'b0;
    for (int i = 0; i < 300; i++) edge_wait();
    check("stats_sat", grant_total, 8'd255);
`endif

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
